// File: rtl/jb_dl_dfe_car2ant_s2p.sv
`default_nettype none
// ============================================================================
// Module   : jb_dl_dfe_car2ant_s2p
// Purpose  : Serial-to-parallel antenna demux for one carrier on clk_4x.
//            Collects a TDM stream carrying one {Q,I} sample per antenna.
//            Each sample is tagged with its antenna index in s_tuser.
//            Emits one aligned vector of all antennas per complete frame.
// Ports    : clk_4x, resetn_4x       clock / async active-low reset
//            enable                  stream enable, low = synchronous flush
//            err_clr                 synchronous clear of err_cnt
//            s_tvalid/s_tdata/s_tuser/s_tready   TDM input (no backpressure)
//            m_tvalid/m_tdata        one-cycle frame pulse / parallel vector
//            locked, seq_err, err_cnt   sync status and error accounting
// Revision : 1.0 - initial release
// ============================================================================
module jb_dl_dfe_car2ant_s2p #(
  parameter int N_ANTENNAS  = 4,
  parameter int PRECISION   = 16,
  parameter int USR_ID_BW   = 2,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic                              clk_4x,
  input  logic                              resetn_4x,
  input  logic                              enable,
  input  logic                              err_clr,
  input  logic                              s_tvalid,
  input  logic [2*PRECISION-1:0]            s_tdata,
  input  logic [USR_ID_BW-1:0]              s_tuser,
  output logic                              s_tready,
  output logic                              m_tvalid,
  output logic [N_ANTENNAS*2*PRECISION-1:0] m_tdata,
  output logic                              locked,
  output logic                              seq_err,
  output logic [15:0]                       err_cnt
);

  localparam int SW    = 2 * PRECISION;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [USR_ID_BW-1:0] IDX_LAST = USR_ID_BW'(N_ANTENNAS - 1);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                      state_q;
  logic [USR_ID_BW-1:0]        exp_idx_q;
  logic [GAP_W-1:0]            gap_cnt_q;
  logic [SW-1:0]               cap_q [N_ANTENNAS];
  logic                        m_tvalid_q;
  logic [N_ANTENNAS*SW-1:0]    m_tdata_q;
  logic                        locked_q;
  logic                        seq_err_q;
  logic [15:0]                 err_cnt_q;
  logic [15:0]                 err_cnt_d;
  logic                        w_err;

  // One error source per cycle at most: stray index while locked in HUNT,
  // out-of-order index in COLLECT, or the idle gap running out in COLLECT.
  assign w_err = enable && (
      (state_q == HUNT    &&  s_tvalid && s_tuser != '0 && locked_q) ||
      (state_q == COLLECT &&  s_tvalid && s_tuser != exp_idx_q)      ||
      (state_q == COLLECT && !s_tvalid && gap_cnt_q == GAP_LAST));

  // Clear wins over accumulation, but an error on the clear cycle still counts.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (enable) begin
      if (err_clr) begin
        err_cnt_d = w_err ? 16'd1 : 16'd0;
      end else if (w_err && err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_4x or negedge resetn_4x) begin
    if (!resetn_4x) begin
      state_q    <= HUNT;
      exp_idx_q  <= '0;
      gap_cnt_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      locked_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      for (int k = 0; k < N_ANTENNAS; k++) begin
        cap_q[k] <= '0;
      end
    end else begin
      m_tvalid_q <= 1'b0;
      seq_err_q  <= w_err;
      err_cnt_q  <= err_cnt_d;
      if (!enable) begin
        state_q   <= HUNT;
        exp_idx_q <= '0;
        gap_cnt_q <= '0;
        locked_q  <= 1'b0;
      end else begin
        if (w_err) begin
          locked_q <= 1'b0;
        end
        case (state_q)
          HUNT: begin
            if (s_tvalid && s_tuser == '0) begin
              cap_q[0]  <= s_tdata;
              exp_idx_q <= USR_ID_BW'(1);
              gap_cnt_q <= '0;
              state_q   <= COLLECT;
            end
          end
          COLLECT: begin
            if (s_tvalid) begin
              gap_cnt_q <= '0;
              if (s_tuser == exp_idx_q) begin
                if (exp_idx_q == IDX_LAST) begin
                  // The last antenna bypasses the buffer straight to the output.
                  for (int k = 0; k < N_ANTENNAS - 1; k++) begin
                    m_tdata_q[k*SW +: SW] <= cap_q[k];
                  end
                  m_tdata_q[(N_ANTENNAS-1)*SW +: SW] <= s_tdata;
                  m_tvalid_q <= 1'b1;
                  locked_q   <= 1'b1;
                  exp_idx_q  <= '0;
                  state_q    <= HUNT;
                end else begin
                  cap_q[exp_idx_q] <= s_tdata;
                  exp_idx_q        <= exp_idx_q + 1'b1;
                end
              end else if (s_tuser == '0) begin
                // A misplaced antenna 0 is taken as the start of a fresh frame.
                cap_q[0]  <= s_tdata;
                exp_idx_q <= USR_ID_BW'(1);
              end else begin
                exp_idx_q <= '0;
                state_q   <= HUNT;
              end
            end else if (gap_cnt_q == GAP_LAST) begin
              exp_idx_q <= '0;
              gap_cnt_q <= '0;
              state_q   <= HUNT;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  // No backpressure: ready simply follows reset.
  assign s_tready = resetn_4x;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign locked   = locked_q;
  assign seq_err  = seq_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jb_dl_dfe_car2ant_s2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_jb_dl_dfe_car2ant_s2p
// Purpose  : Self-checking bench for jb_dl_dfe_car2ant_s2p (N=4, P=16, GAP=8).
//            Directed vector table, hand-written corner sequences, then random
//            traffic checked against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jb_dl_dfe_car2ant_s2p;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int G  = 8;
  localparam int SW = 2 * P;

  logic              clk = 1'b0;
  logic              resetn;
  logic              enable;
  logic              err_clr;
  logic              s_tvalid;
  logic [SW-1:0]     s_tdata;
  logic [1:0]        s_tuser;
  logic              s_tready;
  logic              m_tvalid;
  logic [N*SW-1:0]   m_tdata;
  logic              locked;
  logic              seq_err;
  logic [15:0]       err_cnt;

  always #5 clk = ~clk;

  jb_dl_dfe_car2ant_s2p #(
    .N_ANTENNAS(N), .PRECISION(P), .USR_ID_BW(2), .GAP_TIMEOUT(G)
  ) dut (
    .clk_4x(clk), .resetn_4x(resetn), .enable(enable), .err_clr(err_clr),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .locked(locked),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [N*SW-1:0] act, input logic [N*SW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model: a frame is a queue of accepted samples
  logic [SW-1:0]   mq[$];
  int              mgap;
  bit              m_lk, m_mv, m_se;
  logic [15:0]     m_cnt;
  logic [N*SW-1:0] m_data;

  task automatic mdl_reset();
    mq.delete(); mgap = 0; m_lk = 0; m_mv = 0; m_se = 0; m_cnt = '0; m_data = '0;
  endtask

  task automatic mdl_step(input bit en, input bit clr, input bit v, input logic [1:0] u,
                          input logic [SW-1:0] d);
    bit err;
    err = 0; m_mv = 0; m_se = 0;
    if (!en) begin
      mq.delete(); mgap = 0; m_lk = 0;
      return;
    end
    if (v) begin
      mgap = 0;
      if (mq.size() == 0) begin
        if (u == 0) mq.push_back(d);
        else if (m_lk) err = 1;
      end else if (int'(u) == mq.size()) begin
        mq.push_back(d);
        if (mq.size() == N) begin
          for (int k = 0; k < N; k++) m_data[k*SW +: SW] = mq[k];
          m_mv = 1; m_lk = 1; mq.delete();
        end
      end else begin
        err = 1; mq.delete();
        if (u == 0) mq.push_back(d);
      end
    end else if (mq.size() != 0) begin
      mgap++;
      if (mgap == G) begin err = 1; mq.delete(); mgap = 0; end
    end
    if (err) begin m_se = 1; m_lk = 0; end
    if (clr) m_cnt = err ? 16'd1 : 16'd0;
    else if (err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic drv(input bit en, input bit clr, input bit v, input logic [1:0] u,
                     input logic [SW-1:0] d);
    enable = en; err_clr = clr; s_tvalid = v; s_tuser = u; s_tdata = d;
  endtask

  // One clock: model sees the same inputs as the DUT, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    mdl_step(enable, err_clr, s_tvalid, s_tuser, s_tdata);
    #1;
  endtask

  // ---------------- directed vector table
  typedef struct {
    bit en; bit clr; bit v; logic [1:0] u; logic [SW-1:0] d;
    bit mv; bit se; bit lk; logic [15:0] cnt; bit cd; logic [N*SW-1:0] data;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit clr, input bit v, input logic [1:0] u, input logic [SW-1:0] d,
                     input bit mv, input bit se, input bit lk, input logic [15:0] cnt,
                     input bit cd, input logic [N*SW-1:0] data);
    vec_t e;
    e.en = 1; e.clr = clr; e.v = v; e.u = u; e.d = d; e.mv = mv; e.se = se;
    e.lk = lk; e.cnt = cnt; e.cd = cd; e.data = data;
    tbl.push_back(e);
  endtask

  int mv_seen, se_seen, nxt, idle_left;
  bit r_en, r_clr, r_v;
  logic [1:0] r_u;
  logic [N*SW-1:0] f_exp;

  initial begin
    resetn = 1'b0;
    drv(1, 0, 0, 2'd0, '0);
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mvalid", m_tvalid, 0);
    chk("reset_mdata", m_tdata, 0);
    chk("reset_locked", locked, 0);
    chk("reset_seqerr", seq_err, 0);
    chk("reset_errcnt", err_cnt, 0);
    chk("reset_tready", s_tready, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("tready_out_of_reset", s_tready, 1);

    //  clr v  u  data        mv se lk cnt  cd data
    add(0, 1, 0, 32'h11,       0, 0, 0, 0,  0, '0);
    add(0, 1, 1, 32'h22,       0, 0, 0, 0,  0, '0);
    add(0, 1, 2, 32'h33,       0, 0, 0, 0,  0, '0);
    add(0, 1, 3, 32'h44,       1, 0, 1, 0,  1, 128'h00000044_00000033_00000022_00000011);
    add(0, 1, 0, 32'h55,       0, 0, 1, 0,  0, '0);
    add(0, 1, 1, 32'h66,       0, 0, 1, 0,  0, '0);
    add(0, 1, 3, 32'h77,       0, 1, 0, 1,  1, 128'h00000044_00000033_00000022_00000011);
    add(0, 1, 0, 32'ha1,       0, 0, 0, 1,  0, '0);
    add(0, 1, 1, 32'ha2,       0, 0, 0, 1,  0, '0);
    add(0, 1, 2, 32'ha3,       0, 0, 0, 1,  0, '0);
    add(0, 1, 3, 32'ha4,       1, 0, 1, 1,  1, 128'h000000a4_000000a3_000000a2_000000a1);
    add(0, 1, 0, 32'hb1,       0, 0, 1, 1,  0, '0);
    add(0, 1, 1, 32'hb2,       0, 0, 1, 1,  0, '0);
    add(0, 1, 0, 32'hc1,       0, 1, 0, 2,  0, '0);
    add(0, 1, 1, 32'hc2,       0, 0, 0, 2,  0, '0);
    add(0, 1, 2, 32'hc3,       0, 0, 0, 2,  0, '0);
    add(0, 1, 3, 32'hc4,       1, 0, 1, 2,  1, 128'h000000c4_000000c3_000000c2_000000c1);
    add(0, 0, 0, 32'h0,        0, 0, 1, 2,  1, 128'h000000c4_000000c3_000000c2_000000c1);
    add(0, 1, 2, 32'hd2,       0, 1, 0, 3,  0, '0);
    add(0, 1, 1, 32'hd1,       0, 0, 0, 3,  0, '0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0,  0, '0);
    add(0, 1, 0, 32'he0,       0, 0, 0, 0,  0, '0);
    add(1, 1, 2, 32'he2,       0, 1, 0, 1,  0, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].u, tbl[i].d);
      tick();
      chk($sformatf("tbl%0d_mvalid", i), m_tvalid, tbl[i].mv);
      chk($sformatf("tbl%0d_seqerr", i), seq_err, tbl[i].se);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_errcnt", i), err_cnt, tbl[i].cnt);
      if (tbl[i].cd) chk($sformatf("tbl%0d_mdata", i), m_tdata, tbl[i].data);
    end

    // Three frames with two idle cycles between every sample.
    mv_seen = 0; se_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < N; a++) begin
        drv(1, 0, 1, 2'(a), 32'(16 * f + a + 1));
        tick(); mv_seen += int'(m_tvalid); se_seen += int'(seq_err);
        repeat (2) begin
          drv(1, 0, 0, 2'd0, '0);
          tick(); mv_seen += int'(m_tvalid); se_seen += int'(seq_err);
        end
      end
    end
    chk("gap2_mvalid_pulses", 32'(mv_seen), 3);
    chk("gap2_seqerr_pulses", 32'(se_seen), 0);
    chk("gap2_mdata", m_tdata, 128'h00000024_00000023_00000022_00000021);
    chk("gap2_locked", locked, 1);

    // Gap timeout: antenna 0 then 8 idle cycles.
    drv(1, 0, 1, 2'd0, 32'h99);
    tick();
    se_seen = 0;
    drv(1, 0, 0, 2'd0, '0);
    repeat (G - 1) begin tick(); se_seen += int'(seq_err); end
    chk("timeout_early_seqerr", 32'(se_seen), 0);
    tick();
    chk("timeout_seqerr", seq_err, 1);
    chk("timeout_errcnt", err_cnt, 2);
    chk("timeout_locked", locked, 0);
    tick();
    chk("timeout_pulse_width", seq_err, 0);
    drv(1, 0, 1, 2'd1, 32'h98);   // HUNT and unlocked: dropped silently
    tick();
    chk("timeout_back_in_hunt", seq_err, 0);

    // Seven idle cycles is still within budget.
    drv(1, 0, 1, 2'd0, 32'h70); tick();
    se_seen = 0;
    drv(1, 0, 0, 2'd0, '0);
    repeat (G - 1) begin tick(); se_seen += int'(seq_err); end
    drv(1, 0, 1, 2'd1, 32'h71); tick(); se_seen += int'(seq_err);
    drv(1, 0, 1, 2'd2, 32'h72); tick(); se_seen += int'(seq_err);
    drv(1, 0, 1, 2'd3, 32'h73); tick(); se_seen += int'(seq_err);
    chk("gap7_seqerr", 32'(se_seen), 0);
    chk("gap7_mvalid", m_tvalid, 1);
    chk("gap7_mdata", m_tdata, 128'h00000073_00000072_00000071_00000070);

    // Enable drop mid-frame flushes the partial frame.
    drv(1, 0, 1, 2'd0, 32'hf0); tick();
    drv(1, 0, 1, 2'd1, 32'hf1); tick();
    drv(0, 0, 1, 2'd2, 32'hf2); tick();
    chk("en_low_locked", locked, 0);
    chk("en_low_seqerr", seq_err, 0);
    chk("en_low_errcnt", err_cnt, 2);
    drv(0, 1, 1, 2'd3, 32'hf3); tick();
    chk("en_low_ignores_last", m_tvalid, 0);
    chk("en_low_ignores_clr", err_cnt, 2);
    chk("en_low_mdata_hold", m_tdata, 128'h00000073_00000072_00000071_00000070);
    mv_seen = 0; se_seen = 0;
    for (int a = 0; a < N; a++) begin
      drv(1, 0, 1, 2'(a), 32'(32'he1 + a));
      tick(); mv_seen += int'(m_tvalid); se_seen += int'(seq_err);
    end
    chk("en_restore_mvalid", 32'(mv_seen), 1);
    chk("en_restore_seqerr", 32'(se_seen), 0);
    chk("en_restore_mdata", m_tdata, 128'h000000e4_000000e3_000000e2_000000e1);

    // Asynchronous reset mid-frame.
    drv(1, 0, 1, 2'd0, 32'h51); tick();
    drv(1, 0, 1, 2'd1, 32'h52); tick();
    #2;
    resetn = 1'b0;
    #1;
    mdl_reset();
    chk("areset_mdata", m_tdata, 0);
    chk("areset_locked", locked, 0);
    chk("areset_errcnt", err_cnt, 0);
    chk("areset_tready", s_tready, 0);
    drv(1, 0, 1, 2'd2, 32'h53);
    @(posedge clk); #1;
    chk("areset_mvalid", m_tvalid, 0);
    @(negedge clk);
    resetn = 1'b1;
    mv_seen = 0;
    drv(1, 0, 1, 2'd3, 32'h54); tick(); mv_seen += int'(m_tvalid);
    chk("areset_stale_seqerr", seq_err, 0);
    for (int a = 0; a < N; a++) begin
      drv(1, 0, 1, 2'(a), 32'(32'h61 + a));
      tick(); mv_seen += int'(m_tvalid);
    end
    chk("areset_frame_count", 32'(mv_seen), 1);
    chk("areset_frame_mdata", m_tdata, 128'h00000064_00000063_00000062_00000061);

    // Random traffic against the model.
    nxt = 0; idle_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (idle_left > 0) begin
        idle_left--;
        drv(1, 0, 0, 2'd0, '0);
      end else begin
        r_en  = ($urandom_range(0, 99) != 0);
        r_clr = ($urandom_range(0, 63) == 0);
        r_v   = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 99) < 8) r_u = 2'($urandom_range(0, 3));
        else                           r_u = 2'(nxt);
        if (r_v) nxt = (int'(r_u) + 1) % N;
        if ($urandom_range(0, 199) == 0) idle_left = int'($urandom_range(5, 12));
        drv(r_en, r_clr, r_v, r_u, 32'($urandom));
      end
      tick();
      chk("rnd_mvalid", m_tvalid, m_mv);
      chk("rnd_seqerr", seq_err, m_se);
      chk("rnd_locked", locked, m_lk);
      chk("rnd_errcnt", err_cnt, m_cnt);
      chk("rnd_mdata", m_tdata, m_data);
      chk("rnd_tready", s_tready, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
